cla_seq_ctrl: RTL and testbench
===============================

# cla_seq_ctrl

Multi-cycle, multi-precision adder sequencer built around one WIDTH-bit carry-lookahead slice. It accepts an N = WIDTH*WORDS bit operand pair over a valid/ready handshake and feeds the slice one word per cycle, least-significant word first. The inter-word carry is held in a register between cycles, and the registered N-bit result is returned over a second valid/ready handshake. The block trades latency for area where a full-width lookahead adder is too large.

## Interface
- WIDTH, 4: bits per slice; must be at least 1.
- WORDS, 4: slices per operation; must be at least 1. N = WIDTH*WORDS.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair and carry-in present.
- in_ready  out  1  block can accept an operation; high exactly when the state is IDLE.
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  carry into word 0.
- sub  in  1  subtract request; present only with CLA_SEQ_SUB_EN.
- out_valid  out  1  sum and c_out are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result, registered.
- c_out  out  1  carry out of the top word, registered.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b and c_in into internal registers, clear the word index idx, and go to RUN.
  - RUN: each cycle, the slice computes {cy, s} = a_r[idx] + b_r[idx] + carry_r, where a_r[idx] and b_r[idx] are the idx-th WIDTH-bit words. s is written to sum[idx*WIDTH +: WIDTH], cy is written to carry_r, and idx increments. When idx = WORDS-1, also load c_out from cy and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operands are sampled only at the accept edge; later changes on a, b, c_in and sub have no effect.
- in_valid in RUN or DONE is ignored. The block holds no queue, and the producer must hold in_valid until it sees in_ready.
- sum and c_out stay stable from the cycle out_valid rises until the handshake completes. They keep their last value after the handshake.
- sum words not yet written during RUN are don't-care. The consumer reads them only under out_valid.
- Arithmetic is unsigned modulo 2^N. No overflow flag is produced.
- WORDS=1: RUN lasts exactly one cycle.
- idx register width: max(1, clog2(WORDS)).

## Timing
- Reset (asynchronous assert, synchronous release) puts the block in IDLE with idx=0, carry_r=0, sum=0, c_out=0 and out_valid=0, so in_ready=1.
- Reset asserted in RUN or DONE aborts the operation: out_valid never rises for it, and the result is discarded.
- Accept edge = edge 0.
- Words 0..WORDS-1 are computed on edges 1..WORDS.
- out_valid is high in the cycle after edge WORDS. Latency is therefore WORDS+1 cycles from the accept cycle to the first out_valid cycle.
- With out_ready held high, DONE lasts one cycle, in_ready is high again after edge WORDS+1, and the earliest next accept is edge WORDS+2. Sustained throughput is one operation per WORDS+2 cycles.
- in_ready and out_valid are decoded from the state register only, with no combinational path from any input.
- out_valid and in_ready are never high in the same cycle.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - The sub port exists.
  - If sub=1 at accept, b_r is loaded with ~b, the initial carry_r is forced to 1, and c_in is ignored.
  - The result is a-b mod 2^N. c_out=1 means no borrow (a >= b).
- CLA_SEQ_SUB_EN undefined: no sub port, and the block only adds.

## Structure
- Shared package cla_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams or a typedef. 2'd3 is illegal and recovers to IDLE.
- One sub-module, cla_slice: a combinational WIDTH-bit carry-lookahead adder (generate/propagate per bit, lookahead carry chain) with ports a, b, ci, s, co. It is instantiated once.
- The controller contains the FSM, idx counter, operand registers, carry register and result register.

## Test plan
Defaults WIDTH=4, WORDS=4, N=16.
- Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, sum=16'h0000, c_out=0.
- a=16'h00FF, b=16'h0001, c_in=0 -> sum=16'h0100, c_out=0. out_valid first high 5 cycles after the accept cycle.
- a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1. The carry ripples through all four words.
- Backpressure: out_ready=0 for 6 cycles after out_valid, while in_valid=1 with new operands -> sum and c_out unchanged, in_ready=0, and the new pair is not taken until after the handshake. The second result is correct.
- CLA_SEQ_SUB_EN, two cases:
  - a=16'h1234, b=16'h0234, sub=1 -> sum=16'h1000, c_out=1.
  - a=16'h0000, b=16'h0001, sub=1 -> sum=16'hFFFF, c_out=0.
- Pulse rst_n low two cycles after accept -> out_valid never rises for that operation. The block is back in IDLE, and the next operation (16'h0003+16'h0004) returns 16'h0007.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder sequencer.
// Holds the FSM state encoding and the word-index width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } cla_state_e;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational WIDTH-bit carry-lookahead adder slice.
// Every carry is a flat sum of generate/propagate products.
module cla_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      acc = 1'b0;
      // c[i+1] = OR_j g[j]&p[j+1..i]  |  ci&p[0..i]
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      term = ci;
      for (int k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = acc | term;
    end
  end

  assign s  = p ^ c[WIDTH-1:0];
  assign co = c[WIDTH];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Word-serial multi-precision adder around one cla_slice, LS word first.
// Define CLA_SEQ_SUB_EN to add the sub port (a-b via ~b and carry-in 1).
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   c_in,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   c_out
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  cla_state_e state_q;
  cla_state_e state_d;

  logic [IW-1:0]    idx_q;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic             carry_r;
  logic [N-1:0]     sum_r;
  logic             c_out_r;

  logic [N-1:0]     b_in;
  logic             c0;
  logic [WIDTH-1:0] s_w;
  logic             co_w;
  logic             accept;
  logic             run;

`ifdef CLA_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c0   = sub ? 1'b1 : c_in;
`else
  assign b_in = b;
  assign c0   = c_in;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_ready && in_valid;
  assign run       = (state_q == S_RUN);
  assign sum       = sum_r;
  assign c_out     = c_out_r;

  cla_slice #(.WIDTH(WIDTH)) u_slice (
    .a  (a_r[idx_q*WIDTH +: WIDTH]),
    .b  (b_r[idx_q*WIDTH +: WIDTH]),
    .ci (carry_r),
    .s  (s_w),
    .co (co_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b_in;
      carry_r <= c0;
      idx_q   <= '0;
    end else if (run) begin
      sum_r[idx_q*WIDTH +: WIDTH] <= s_w;
      carry_r <= co_w;
      idx_q   <= idx_q + 1'b1;
      if (idx_q == LAST) c_out_r <= co_w;
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed self-checking bench for cla_seq_ctrl at WIDTH=4, WORDS=4.
// Subtract vectors run only when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        c_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_seq_ctrl #(.WIDTH(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, return #1 after the accept edge with inputs scrambled.
  task automatic send(input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; c_in = ci; sub = sb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hA5C3; b = 16'h3C5A; c_in = ~ci; sub = ~sb;
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 32'd5);
  endtask

  task automatic check_res(input string tag, input logic [15:0] es,
                           input logic ec);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic hs(input string tag, input logic [15:0] es);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovld_lo"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_hi"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_hold"}, {16'd0, sum}, {16'd0, es});
  endtask

  task automatic op(input string tag, input logic [15:0] av,
                    input logic [15:0] bv, input logic ci, input logic sb,
                    input logic [15:0] es, input logic ec);
    send(av, bv, ci, sb);
    wait_valid(tag);
    check_res(tag, es, ec);
    hs(tag, es);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
    chk("rst_ovld", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_inrdy", {31'd0, in_ready}, 32'd1);

    op("add1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    op("mix", 16'h9ABC, 16'h7654, 1'b1, 1'b0, 16'h1111, 1'b1);

    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid("bp1");
    check_res("bp1", 16'h3333, 1'b0);
    in_valid = 1'b1;
    a = 16'h8000; b = 16'h8000; c_in = 1'b1; sub = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_sum", {16'd0, sum}, 32'h3333);
      chk("bp_cout", {31'd0, c_out}, 32'd0);
      chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
      chk("bp_ovld", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = 16'h0F0F; b = 16'hF0F0; c_in = 1'b0;
    chk("bp_taken", {31'd0, in_ready}, 32'd0);
    wait_valid("bp2");
    check_res("bp2", 16'h0001, 1'b1);
    hs("bp2", 16'h0001);

`ifdef CLA_SEQ_SUB_EN
    op("sub1", 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1);
    op("sub2", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0);
`endif

    send(16'h5555, 16'h1111, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    chk("abort_ovld", {31'd0, out_valid}, 32'd0);
    chk("abort_inrdy", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_never", seen, 32'd0);
    chk("abort_idle", {31'd0, in_ready}, 32'd1);
    op("post", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
